// File: rtl/serial_subtractor_nbit.sv
// rtl/serial_subtractor_nbit.sv - bit-serial unsigned subtractor, one bit per clock
// Result and final borrow update only on entry to DONE and hold across later starts.
module serial_subtractor_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 borrow_in,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] diff,
  output logic                 underflow
);

  localparam int CW = $clog2(BIT_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [BIT_WIDTH-1:0] a_q;
  logic [BIT_WIDTH-1:0] b_q;
  logic [BIT_WIDTH-1:0] res_q;
  logic [BIT_WIDTH-1:0] res_d;
  logic [BIT_WIDTH:0]   res_ext;
  logic [BIT_WIDTH-1:0] diff_q;
  logic                 underflow_q;
  logic                 borrow_q;
  logic                 borrow_d;
  logic                 d_bit;
  logic                 last_bit;
  logic [CW-1:0]        cnt_q;

  // Full-subtractor cell on the LSBs of the working registers.
  assign d_bit    = a_q[0] ^ b_q[0] ^ borrow_q;
  assign borrow_d = (~a_q[0] & b_q[0]) | (~a_q[0] & borrow_q) | (b_q[0] & borrow_q);
  assign res_ext  = {d_bit, res_q};
  assign res_d    = res_ext[BIT_WIDTH:1];
  assign last_bit = (cnt_q == CW'(BIT_WIDTH - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= borrow_in;
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          borrow_q <= borrow_d;
          res_q    <= res_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_bit) begin
            diff_q      <= res_d;
            underflow_q <= borrow_d;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign diff      = diff_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// tb/tb_serial_subtractor_nbit.sv - self-checking bench for serial_subtractor_nbit (4- and 8-bit)
module tb_serial_subtractor_nbit;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start4, bin4, busy4, done4, uf4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bin8, busy8, done8, uf8;
  logic [7:0] a8, b8, diff8;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev4, prev8;
  logic        prevuf4, prevuf8;

  always #5 clk = ~clk;

  serial_subtractor_nbit #(.BIT_WIDTH(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .underflow(uf4)
  );

  serial_subtractor_nbit #(.BIT_WIDTH(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .underflow(uf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the operands.
  function automatic logic [31:0] ref_diff(input int w, input int av, input int bv, input int bi);
    longint r;
    r = longint'(av) - longint'(bv) - longint'(bi);
    return 32'(r & ((64'd1 << w) - 1));
  endfunction

  function automatic logic ref_uf(input int av, input int bv, input int bi);
    return (av < bv + bi);
  endfunction

  task automatic op4(input int av, input int bv, input int bi);
    logic [31:0] ed;
    logic        eu;
    ed = ref_diff(4, av, bv, bi);
    eu = ref_uf(av, bv, bi);
    @(negedge clk);
    a4 = 4'(av); b4 = 4'(bv); bin4 = bi[0]; start4 = 1'b1;
    @(posedge clk); #1;
    chk("w4_busy_after_accept", 32'(busy4), 32'd1);
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("w4_no_early_done", 32'(done4), 32'd0);
      chk("w4_diff_held_calc", 32'(diff4), prev4);
    end
    @(posedge clk); #1;
    chk("w4_done_pulse", 32'(done4), 32'd1);
    chk("w4_busy_in_done", 32'(busy4), 32'd1);
    chk("w4_diff", 32'(diff4), ed);
    chk("w4_underflow", 32'(uf4), 32'(eu));
    @(posedge clk); #1;
    chk("w4_done_drops", 32'(done4), 32'd0);
    chk("w4_busy_drops", 32'(busy4), 32'd0);
    chk("w4_diff_hold_idle", 32'(diff4), ed);
    prev4 = ed; prevuf4 = eu;
  endtask

  task automatic op8(input int av, input int bv, input int bi);
    logic [31:0] ed;
    logic        eu;
    ed = ref_diff(8, av, bv, bi);
    eu = ref_uf(av, bv, bi);
    @(negedge clk);
    a8 = 8'(av); b8 = 8'(bv); bin8 = bi[0]; start8 = 1'b1;
    @(posedge clk); #1;
    chk("w8_busy_after_accept", 32'(busy8), 32'd1);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      chk("w8_no_early_done", 32'(done8), 32'd0);
      chk("w8_uf_held_calc", 32'(uf8), 32'(prevuf8));
    end
    @(posedge clk); #1;
    chk("w8_done_pulse", 32'(done8), 32'd1);
    chk("w8_diff", 32'(diff8), ed);
    chk("w8_underflow", 32'(uf8), 32'(eu));
    @(posedge clk); #1;
    chk("w8_done_drops", 32'(done8), 32'd0);
    chk("w8_busy_drops", 32'(busy8), 32'd0);
    prev8 = ed; prevuf8 = eu;
  endtask

  initial begin
    n_rst = 1'b0;
    start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
    start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    prev4 = 0; prev8 = 0; prevuf4 = 0; prevuf8 = 0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy4), 32'd0);
    chk("post_rst_done", 32'(done4), 32'd0);
    chk("post_rst_diff", 32'(diff4), 32'd0);
    chk("post_rst_uf", 32'(uf4), 32'd0);
    chk("post_rst_busy8", 32'(busy8), 32'd0);

    // Directed 4-bit cases
    op4(9, 4, 0);
    op4(3, 5, 0);
    op4(0, 0, 1);
    op4(7, 7, 0);
    op4(15, 15, 1);

    // Start while busy: 12-3, with ignored starts at k+2 and in DONE
    @(negedge clk); a4 = 12; b4 = 3; bin4 = 0; start4 = 1;
    @(posedge clk); #1;                                   // edge k
    @(negedge clk); start4 = 0;
    @(posedge clk); #1;                                   // k+1
    @(negedge clk); a4 = 1; b4 = 2; start4 = 1;
    @(posedge clk); #1;                                   // k+2
    chk("swb_busy_k2", 32'(busy4), 32'd1);
    @(negedge clk); start4 = 0;
    @(posedge clk); #1;                                   // k+3
    chk("swb_no_done_k3", 32'(done4), 32'd0);
    @(posedge clk); #1;                                   // k+4
    chk("swb_done", 32'(done4), 32'd1);
    chk("swb_diff", 32'(diff4), 32'd9);
    chk("swb_uf", 32'(uf4), 32'd0);
    @(negedge clk); start4 = 1;
    @(posedge clk); #1;                                   // k+5
    chk("swb_done_single", 32'(done4), 32'd0);
    chk("swb_busy_falls", 32'(busy4), 32'd0);
    chk("swb_diff_kept", 32'(diff4), 32'd9);
    @(negedge clk); start4 = 0;
    prev4 = 9; prevuf4 = 0;
    op4(10, 3, 1);

    // Reset mid-operation
    op4(9, 4, 0);
    @(negedge clk); a4 = 15; b4 = 1; bin4 = 0; start4 = 1;
    @(posedge clk); #1;
    @(negedge clk); start4 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_diff_before", 32'(diff4), 32'd5);
    n_rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_diff", 32'(diff4), 32'd0);
    chk("abort_uf", 32'(uf4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done4), 32'd0);
    end
    @(negedge clk); n_rst = 1'b1;
    prev4 = 0; prevuf4 = 0; prev8 = 0; prevuf8 = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_abort_no_done", 32'(done4), 32'd0);
    end
    op4(6, 6, 0);

    // 8-bit instance
    op8(8'h80, 8'h01, 0);
    op8(8'h00, 8'hFF, 1);
    op8(8'hFF, 8'h00, 0);

    // Randomised
    for (int i = 0; i < 20; i++) begin
      op4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
      op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor_nbit.md
Name: serial_subtractor_nbit

Overview:
- Bit-serial unsigned subtractor with a borrow chain, the inverse operation of the team's ripple-carry n-bit adder.
- Computes diff = a - b - borrow_in one bit per clock through a single full-subtractor cell and a registered borrow.
- Trades latency for area in datapaths where one n-bit subtract per several cycles is enough.
- Handshake is start / busy / done; result is held until the next operation completes.

Parameters:
- BIT_WIDTH, 4, operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  system clock, all state on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only on a rising edge where busy=0.
- a  input  BIT_WIDTH  minuend, captured when start is accepted.
- b  input  BIT_WIDTH  subtrahend, captured when start is accepted.
- borrow_in  input  1  initial borrow, captured when start is accepted.
- busy  output  1  high while an operation is in progress (state != IDLE).
- done  output  1  one-cycle pulse when diff/underflow become valid.
- diff  output  BIT_WIDTH  result, (a - b - borrow_in) mod 2^BIT_WIDTH.
- underflow  output  1  final borrow out: 1 iff a < b + borrow_in, unsigned.

Behaviour:
- Reset is asynchronous, n_rst=0:
  - state=IDLE, busy=0, done=0, diff=0, underflow=0.
  - Operand shift registers, borrow flop and bit counter clear.
  - Applies immediately and also aborts any operation in progress; no done is issued for an aborted operation.
- States are IDLE, CALC and DONE. All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- IDLE:
  - On an edge with start=1, capture a, b and borrow_in into working registers, set the counter to 0, go to CALC.
  - With start=0, stay in IDLE.
- CALC, on each edge:
  - Bit i is the LSB of the working registers.
  - d_i = a_i XOR b_i XOR borrow.
  - borrow_next = (~a_i & b_i) | (~a_i & borrow) | (b_i & borrow).
  - Shift d_i into the MSB of the result shift register; shift the operand registers right by 1; increment the counter.
  - On the edge processing bit BIT_WIDTH-1, go to DONE. Load diff with the full result and underflow with borrow_next in the same edge.
- DONE:
  - done=1 for exactly one cycle, then unconditional return to IDLE.
  - busy remains 1 in DONE.
- Latency:
  - Start is accepted at edge k.
  - done is high during the cycle following edge k+BIT_WIDTH.
  - The next start is accepted no earlier than edge k+BIT_WIDTH+2.
  - Throughput is one operation per BIT_WIDTH+2 cycles.
- diff and underflow change only on the edge that enters DONE. They hold the previous result during IDLE and CALC, and across later starts, until the next completion.
- start while busy=1, including in the DONE cycle, is ignored and not queued. Changes on a, b or borrow_in after acceptance have no effect.
- BIT_WIDTH=1: CALC lasts one edge; done appears in the cycle after edge k+1.
- Counter width is clog2(BIT_WIDTH)+1 bits. The counter must not wrap before the terminal compare.

Test Plan:
- Reset: hold n_rst=0 for 2 cycles, release -> busy=0, done=0, diff=0, underflow=0.
- BIT_WIDTH=4, a=9, b=4, borrow_in=0, start for 1 cycle at edge k:
  - diff=5, underflow=0.
  - done high only in the cycle after edge k+4; busy high from after edge k through the done cycle.
- BIT_WIDTH=4, a=3, b=5, borrow_in=0 -> diff=14, underflow=1.
- BIT_WIDTH=4, a=0, b=0, borrow_in=1 -> diff=15, underflow=1.
- BIT_WIDTH=4, a=b=7, borrow_in=0 -> diff=0, underflow=0.
- Start-while-busy:
  - Start a=12, b=3 (-> 9).
  - Pulse start with a=1, b=2 two cycles later, and again in the DONE cycle.
  - Required: a single done, diff=9, busy falls one cycle after done.
  - A start in the first IDLE cycle is then accepted.
- Reset mid-operation:
  - After a completed result diff=5, start a=15, b=1.
  - Assert n_rst=0 after 2 CALC edges -> immediate busy=0, diff=0, no done pulse.
  - After release, a new start a=6, b=6 -> diff=0, underflow=0.
- BIT_WIDTH=8 instance:
  - a=0x80, b=0x01 -> diff=0x7F, underflow=0, done after edge k+8.
  - a=0x00, b=0xFF, borrow_in=1 -> diff=0x00, underflow=1.
